// File: rtl/serial_tx_arbiter.sv
// Round-robin arbiter sharing one serial_tx byte channel among PORTS requesters.
// A grant lasts for a whole message, with optional forced rotation after MAX_BYTES bytes.
module serial_tx_arbiter #(
   parameter int PORTS     = 4,
   parameter int MAX_BYTES = 16,
   parameter int PORT_BITS = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [PORTS-1:0]     req,
   output logic [PORTS-1:0]     gnt,
   input  logic [8*PORTS-1:0]   data,
   input  logic [PORTS-1:0]     new_data,
   output logic [PORTS-1:0]     busy,
   output logic [7:0]           tx_data,
   output logic                 new_tx_data,
   input  logic                 tx_busy
);

   localparam int CNT_W = (MAX_BYTES < 1) ? 1 : $clog2(MAX_BYTES + 1);
   localparam logic [CNT_W-1:0]     CNT_MAX   = CNT_W'(MAX_BYTES);
   localparam logic [PORT_BITS-1:0] LAST_PORT = PORT_BITS'(PORTS - 1);
   localparam bit                   ROTATE_EN = (MAX_BYTES != 0);

   typedef enum logic [1:0] {
      IDLE  = 2'b01,
      GRANT = 2'b10
   } state_t;

   state_t               state_q, state_d;
   logic [PORT_BITS-1:0] owner_q, owner_d;
   logic [PORT_BITS-1:0] last_q, last_d;
   logic [CNT_W-1:0]     count_q, count_d;
   logic [PORTS-1:0]     gnt_q, gnt_d;
   logic [7:0]           tx_data_q, tx_data_d;
   logic                 new_tx_q, new_tx_d;
   logic                 guard_q;

   logic                 chan_free;
   logic                 found;
   logic [PORT_BITS-1:0] winner;
   logic [PORT_BITS-1:0] cand;
   logic                 owner_req;
   logic                 owner_accept;
   logic [7:0]           owner_byte;
   logic                 others_pending;
   logic                 rotate;

   // The channel is blocked while serial_tx is busy, in the strobe cycle, and in the
   // cycle after it, before serial_tx has had a chance to raise tx_busy.
   assign chan_free = !(tx_busy || new_tx_q || guard_q);

   assign owner_req      = req[owner_q];
   assign owner_byte     = data[{owner_q, 3'b000} +: 8];
   assign owner_accept   = new_data[owner_q] && gnt_q[owner_q] && chan_free;
   assign others_pending = |(req & ~gnt_q);
   assign rotate         = ROTATE_EN && (count_q == CNT_MAX) && others_pending;

   // First requester found scanning from last+1 around to last itself.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      cand   = '0;
      for (int k = 1; k <= PORTS; k++) begin
         cand = PORT_BITS'((int'(last_q) + k) % PORTS);
         if (!found && req[cand]) begin
            found  = 1'b1;
            winner = cand;
         end
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register samples its peers' pre-edge values.
      if (rst) begin
         state_q   <= IDLE;
         owner_q   <= '0;
         last_q    <= LAST_PORT;
         count_q   <= '0;
         gnt_q     <= '0;
         tx_data_q <= '0;
         new_tx_q  <= 1'b0;
         guard_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         last_q    <= last_d;
         count_q   <= count_d;
         gnt_q     <= gnt_d;
         tx_data_q <= tx_data_d;
         new_tx_q  <= new_tx_d;
         guard_q   <= new_tx_q;
      end
   end

   always_comb begin
      // NOTE: every signal gets a default first so no branch can leave one unassigned and infer a latch.
      state_d   = state_q;
      owner_d   = owner_q;
      last_d    = last_q;
      count_d   = count_q;
      gnt_d     = gnt_q;
      tx_data_d = tx_data_q;
      new_tx_d  = 1'b0;
      case (state_q)
         GRANT: begin
            if (owner_accept) begin
               tx_data_d = owner_byte;
               new_tx_d  = 1'b1;
               if (count_q != CNT_MAX) begin
                  count_d = count_q + 1'b1;
               end
            end
            // A byte accepted in the releasing cycle is still sent above.
            if (!owner_req || rotate) begin
               state_d = IDLE;
               gnt_d   = '0;
            end
         end
         default: begin
            gnt_d = '0;
            if (found) begin
               state_d       = GRANT;
               owner_d       = winner;
               last_d        = winner;
               count_d       = '0;
               gnt_d[winner] = 1'b1;
            end else begin
               state_d = IDLE;
            end
         end
      endcase
   end

   always_comb begin
      gnt         = gnt_q;
      busy        = ~gnt_q | {PORTS{!chan_free}};
      tx_data     = tx_data_q;
      new_tx_data = new_tx_q;
   end

endmodule
